// File: rtl/jk_flop_bank.sv
// jk_flop_bank: WIDTH independent 74LS109-style J/K-bar flops with shared ce; optional JK_FLOP_BANK_CHECK_EN adds preset+clear violation tracking
module jk_flop_bank #(
   parameter int               WIDTH   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k_n,
   input  logic [WIDTH-1:0] pre_n,
   input  logic [WIDTH-1:0] clr_n,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] viol,
   output logic [CNT_W-1:0] viol_cnt,
   input  logic             viol_clr
);
   logic [WIDTH-1:0] s, s_jk;
   // J/K-bar 00 clears, 01 holds, 10 toggles, 11 sets
   always_comb s_jk = (j & (k_n | ~s)) | (k_n & s);
   always_ff @(posedge clk or posedge reset)
      if (reset) s <= RST_VAL;
      else       s <= ((ce ? s_jk : s) | ~pre_n) & clr_n;
   // both overrides low drives q and q_n high, as the TTL part does
   assign q   = ~pre_n | (s & clr_n);
   assign q_n = ~clr_n | (~s & pre_n);
`ifdef JK_FLOP_BANK_CHECK_EN
   logic [WIDTH-1:0] bad;
   assign bad = ~pre_n & ~clr_n;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         viol     <= '0;
         viol_cnt <= '0;
      end else if (viol_clr) begin
         viol     <= '0;
         viol_cnt <= '0;
      end else begin
         viol <= viol | bad;
         if (|bad && !(&viol_cnt)) viol_cnt <= viol_cnt + CNT_W'(1);
      end
`else
   logic unused_viol_clr;
   assign unused_viol_clr = viol_clr;
   assign viol     = '0;
   assign viol_cnt = '0;
`endif
endmodule

// File: tb/tb_jk_flop_bank.sv
// tb_jk_flop_bank: randomized scoreboard bench for jk_flop_bank against a rule-level reference model
module tb_jk_flop_bank;
   localparam int          W  = 4;
   localparam int          CW = 2;
   localparam logic [W-1:0] RV = 4'b1010;
   logic clk = 1'b0, reset, ce, viol_clr;
   logic [W-1:0] j, k_n, pre_n, clr_n, q, q_n, viol;
   logic [CW-1:0] viol_cnt;
   typedef struct packed {
      logic [W-1:0]  q, q_n, viol;
      logic [CW-1:0] cnt;
   } exp_t;
   exp_t  sb[$];
   string nm[$];
   int    tests = 0, fails = 0;
   bit    m_s[W];
   bit    m_viol[W];
   int    m_cnt;
   event  chk_ev;

   jk_flop_bank #(.WIDTH(W), .CNT_W(CW), .RST_VAL(RV)) dut (
      .clk(clk), .reset(reset), .ce(ce), .j(j), .k_n(k_n), .pre_n(pre_n), .clr_n(clr_n),
      .q(q), .q_n(q_n), .viol(viol), .viol_cnt(viol_cnt), .viol_clr(viol_clr));

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < W; i++) begin
         m_s[i]    = RV[i];
         m_viol[i] = 1'b0;
      end
      m_cnt = 0;
   endtask

   // rule-level behaviour of one rising edge, channel by channel
   task automatic model_edge();
      bit any;
      any = 1'b0;
      if (reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < W; i++) begin
         if (!pre_n[i] && !clr_n[i]) any = 1'b1;
         if (viol_clr) m_viol[i] = 1'b0;
         else if (!pre_n[i] && !clr_n[i]) m_viol[i] = 1'b1;
         if (!clr_n[i]) m_s[i] = 1'b0;
         else if (!pre_n[i]) m_s[i] = 1'b1;
         else if (ce) begin
            if (j[i] && k_n[i]) m_s[i] = 1'b1;
            else if (j[i] && !k_n[i]) m_s[i] = !m_s[i];
            else if (!j[i] && !k_n[i]) m_s[i] = 1'b0;
         end
      end
      if (viol_clr) m_cnt = 0;
      else if (any && m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   task automatic expect_now(input string n);
      exp_t e;
      e = '0;
      for (int i = 0; i < W; i++) begin
         if (!pre_n[i] && !clr_n[i]) begin e.q[i] = 1; e.q_n[i] = 1; end
         else if (!pre_n[i])         begin e.q[i] = 1; e.q_n[i] = 0; end
         else if (!clr_n[i])         begin e.q[i] = 0; e.q_n[i] = 1; end
         else                        begin e.q[i] = m_s[i]; e.q_n[i] = !m_s[i]; end
`ifdef JK_FLOP_BANK_CHECK_EN
         e.viol[i] = m_viol[i];
`endif
      end
`ifdef JK_FLOP_BANK_CHECK_EN
      e.cnt = CW'(m_cnt);
`endif
      sb.push_back(e);
      nm.push_back(n);
      ->chk_ev;
      #3;
   endtask

   task automatic cyc(input string n);
      @(posedge clk);
      model_edge();
      #1;
      expect_now(n);
   endtask

   task automatic set_in(input logic c, input logic [W-1:0] jj, kk, pp, cc, input logic vc);
      ce = c; j = jj; k_n = kk; pre_n = pp; clr_n = cc; viol_clr = vc;
   endtask

   initial forever begin
      exp_t  e;
      string n;
      @(chk_ev);
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n = nm.pop_front();
         tests++;
         if (q !== e.q || q_n !== e.q_n || viol !== e.viol || viol_cnt !== e.cnt) begin
            fails++;
            $display("FAIL %s: got q=%b q_n=%b viol=%b cnt=%0d, want q=%b q_n=%b viol=%b cnt=%0d",
                     n, q, q_n, viol, viol_cnt, e.q, e.q_n, e.viol, e.cnt);
         end
      end
   end

   initial begin
      reset = 1'b1;
      set_in(1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      model_reset();
      #2;
      expect_now("reset_state");
      cyc("reset_held");
      reset = 1'b0;
      repeat (3) cyc("hold_after_reset");
      // truth table on channel 0 (s[0]=0 from RST_VAL)
      set_in(1'b1, 4'b0001, 4'b1110, 4'b1111, 4'b1111, 1'b0);
      cyc("toggle_1");
      cyc("toggle_2");
      set_in(1'b1, 4'b0001, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      cyc("jk_11");
      set_in(1'b1, 4'b0000, 4'b1110, 4'b1111, 4'b1111, 1'b0);
      cyc("jk_00");
      set_in(1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      cyc("jk_01");
      // preset pulse without an edge, then across an edge
      @(posedge clk);
      model_edge();
      #1;
      pre_n = 4'b1011;
      expect_now("pre_pulse");
      pre_n = 4'b1111;
      expect_now("pre_revert");
      pre_n = 4'b1011;
      cyc("pre_edge");
      pre_n = 4'b1111;
      expect_now("pre_kept");
      // illegal preset+clear on channel 1
      pre_n = 4'b1101; clr_n = 4'b1101;
      cyc("illegal_1");
      cyc("illegal_2");
      pre_n = 4'b1111; clr_n = 4'b1111;
      expect_now("illegal_release");
      // ce gating
      set_in(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0);
      repeat (5) cyc("ce_low_hold");
      ce = 1'b1;
      cyc("ce_toggle_all");
      // counter saturation, then clear winning over a concurrent violation
      set_in(1'b1, 4'b0000, 4'b1111, 4'b1110, 4'b1110, 1'b0);
      repeat (5) cyc("viol_saturate");
      viol_clr = 1'b1;
      cyc("viol_clr_wins");
      set_in(1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0);
      cyc("viol_cleared");
      // asynchronous reset in the middle of a toggle run
      set_in(1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0);
      cyc("toggle_run_1");
      cyc("toggle_run_2");
      reset = 1'b1;
      model_reset();
      expect_now("async_reset");
      pre_n = 4'b0111;
      expect_now("override_in_reset");
      pre_n = 4'b1111;
      cyc("reset_edge");
      reset = 1'b0;
      cyc("after_reset_toggle");
      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         set_in(($urandom_range(3) != 0), W'($urandom), W'($urandom),
                ($urandom_range(3) == 0) ? W'($urandom) : '1,
                ($urandom_range(3) == 0) ? W'($urandom) : '1,
                ($urandom_range(15) == 0));
         if ($urandom_range(63) == 0) begin
            reset = 1'b1;
            model_reset();
         end
         cyc("random");
         reset = 1'b0;
      end
      #20;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
